// File: rtl/ext_pkg.sv
// Shared encodings and widths for the immediate extender, decoder and ALU operand mux.
package ext_pkg;

  localparam int IMM_W  = 16;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    EXT_ZERO = 2'b00,
    EXT_SIGN = 2'b01,
    EXT_LUI  = 2'b10,
    EXT_RSVD = 2'b11
  } ext_op_e;

endpackage

// File: rtl/ext_core.sv
// Combinational extension select: widens the instruction immediate according to ExtOp.
module ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = IMM_W,
  parameter int OUT_W = WORD_W
) (
  input  logic [IN_W-1:0]  imm16,
  input  logic [1:0]       ExtOp,
  output logic [OUT_W-1:0] next_imm32
);

  // The reserved encoding falls into the default arm, so it behaves as zero-extend.
  always_comb begin
    next_imm32 = {{(OUT_W-IN_W){1'b0}}, imm16};
    case (ExtOp)
      EXT_SIGN: next_imm32 = {{(OUT_W-IN_W){imm16[IN_W-1]}}, imm16};
      EXT_LUI:  next_imm32 = {imm16, {(OUT_W-IN_W){1'b0}}};
      default:  next_imm32 = {{(OUT_W-IN_W){1'b0}}, imm16};
    endcase
  end

endmodule

// File: rtl/ext.sv
// Registered 16-to-32-bit immediate extender for the decode/execute boundary.
module ext
  import ext_pkg::*;
#(
  parameter int IN_W  = IMM_W,
  parameter int OUT_W = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  imm16,
  output logic [OUT_W-1:0] imm32,
  input  logic [1:0]       ExtOp
);

  logic [OUT_W-1:0] next_imm32;

  // Load-upper places the immediate exactly in the high half, so the widths must pair up.
  if (OUT_W != 2*IN_W) begin : g_width_check
    $error("ext: OUT_W must equal 2*IN_W");
  end

  ext_core #(
    .IN_W (IN_W),
    .OUT_W(OUT_W)
  ) u_core (
    .imm16     (imm16),
    .ExtOp     (ExtOp),
    .next_imm32(next_imm32)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) imm32 <= '0;
    else     imm32 <= next_imm32;
  end

endmodule

// File: tb/tb_ext.sv
// Self-checking bench for ext: directed cases plus randomized traffic against an arithmetic reference.
module tb_ext;

  logic        clk;
  logic        rst;
  logic [15:0] imm16;
  logic [31:0] imm32;
  logic [1:0]  ExtOp;

  int total = 0;
  int bad   = 0;

  ext dut (
    .clk  (clk),
    .rst  (rst),
    .imm16(imm16),
    .imm32(imm32),
    .ExtOp(ExtOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] v, input logic [1:0] op);
    imm16 = v;
    ExtOp = op;
  endtask

  // Reference built from the operation table using plain integer arithmetic.
  function automatic logic [31:0] refModel(input logic [1:0] op, input logic [15:0] v);
    int unsigned u;
    u = v;
    case (op)
      2'b01:   return (u >= 32768) ? u + 32'hFFFF_0000 : u;
      2'b10:   return u * 65536;
      default: return u;
    endcase
  endfunction

  typedef struct {
    logic [15:0] v;
    logic [1:0]  op;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];
  logic [31:0] expect_q;

  initial begin
    vecs[0] = '{16'hFBCD, 2'b00, 32'h0000_FBCD};
    vecs[1] = '{16'hFBCD, 2'b01, 32'hFFFF_FBCD};
    vecs[2] = '{16'hFBCD, 2'b10, 32'hFBCD_0000};
    vecs[3] = '{16'h1234, 2'b00, 32'h0000_1234};
    vecs[4] = '{16'h1234, 2'b01, 32'h0000_1234};
    vecs[5] = '{16'h1234, 2'b10, 32'h1234_0000};
    vecs[6] = '{16'h8001, 2'b11, 32'h0000_8001};

    rst = 1'b1;
    applyStimulus(16'($urandom), 2'($urandom));
    #1 checkOutput("reset_immediate", imm32, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk) applyStimulus(16'($urandom), 2'($urandom));
      @(posedge clk) #1 checkOutput("reset_held", imm32, 32'h0);
    end

    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk) applyStimulus(vecs[i].v, vecs[i].op);
      @(posedge clk) #1 checkOutput($sformatf("directed_%0d", i), imm32, vecs[i].exp);
    end

    // Mid-cycle input change must not reach the output before the next edge.
    applyStimulus(16'hA5A5, 2'b10);
    #2 checkOutput("midcycle_hold", imm32, 32'h0000_8001);
    @(negedge clk) checkOutput("midcycle_hold_neg", imm32, 32'h0000_8001);
    @(posedge clk) #1 checkOutput("midcycle_update", imm32, 32'hA5A5_0000);

    for (int i = 0; i < 3; i++) begin
      @(posedge clk) #1 checkOutput($sformatf("hold_%0d", i), imm32, 32'hA5A5_0000);
    end

    @(negedge clk) applyStimulus(16'hFBCD, 2'b10);
    @(posedge clk) #1 checkOutput("pre_async", imm32, 32'hFBCD_0000);
    @(negedge clk) rst = 1'b1;
    #1 checkOutput("async_clear", imm32, 32'h0);
    #1 rst = 1'b0;
    #1 checkOutput("async_stays_clear", imm32, 32'h0);
    @(posedge clk) #1 checkOutput("async_resume", imm32, 32'hFBCD_0000);

    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 15) == 0);
      applyStimulus(16'($urandom), 2'($urandom));
      expect_q = rst ? 32'h0 : refModel(ExtOp, imm16);
      @(posedge clk) #1 checkOutput($sformatf("random_%0d", i), imm32, expect_q);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
